// File: rtl/rom_fetch_master_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rom_fetch_master_pkg : shared AXI widths, line geometry and FSM state type
// rev 1.0
// ---------------------------------------------------------------------------
package rom_fetch_master_pkg;

   localparam int AXI_ID_BITS   = 4;
   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_LEN_BITS  = 8;

   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam int DEFAULT_BURST_LEN = 3;
   localparam int BEATS    = DEFAULT_BURST_LEN + 1;
   localparam int IDX_BITS = $clog2(BEATS);
   localparam int OFF_BITS = IDX_BITS + 2;

   localparam int IDLE_BIT = 0;
   localparam int AR_BIT   = 1;
   localparam int R_BIT    = 2;
   localparam int RESP_BIT = 3;

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_AR   = 4'b0010,
      S_R    = 4'b0100,
      S_RESP = 4'b1000
   } rom_fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/AXI_master_intf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// AXI_master_intf : AXI4 bundle with master/slave views
// rev 1.0
// ---------------------------------------------------------------------------
interface AXI_master_intf;
   import rom_fetch_master_pkg::*;

   logic [AXI_ID_BITS-1:0]     arid;
   logic [AXI_ADDR_BITS-1:0]   araddr;
   logic [AXI_LEN_BITS-1:0]    arlen;
   logic [2:0]                 arsize;
   logic [1:0]                 arburst;
   logic                       arvalid;
   logic                       arready;

   logic [AXI_ID_BITS-1:0]     rid;
   logic [AXI_DATA_BITS-1:0]   rdata;
   logic [1:0]                 rresp;
   logic                       rlast;
   logic                       rvalid;
   logic                       rready;

   logic [AXI_ID_BITS-1:0]     awid;
   logic [AXI_ADDR_BITS-1:0]   awaddr;
   logic [AXI_LEN_BITS-1:0]    awlen;
   logic [2:0]                 awsize;
   logic [1:0]                 awburst;
   logic                       awvalid;
   logic                       awready;

   logic [AXI_DATA_BITS-1:0]   wdata;
   logic [AXI_DATA_BITS/8-1:0] wstrb;
   logic                       wlast;
   logic                       wvalid;
   logic                       wready;

   logic [AXI_ID_BITS-1:0]     bid;
   logic [1:0]                 bresp;
   logic                       bvalid;
   logic                       bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready
   );

endinterface
`default_nettype wire

// File: rtl/rom_fetch_master_line_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_line_buf : one-line instruction buffer with tag compare and read mux
// rev 1.0
// ---------------------------------------------------------------------------
module fetch_line_buf
   import rom_fetch_master_pkg::*;
#(
   parameter int IDX_W = IDX_BITS,
   parameter int TAG_W = 32 - OFF_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic             tag_load,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             set_valid,
   input  logic             clr_valid,
   input  logic [TAG_W-1:0] lookup_tag,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             hit,
   output logic [31:0]      rd_data,
   output logic [TAG_W-1:0] tag_r
);

   logic [31:0] line_mem [2**IDX_W];
   logic        line_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         line_valid <= 1'b0;
         tag_r      <= '0;
      end else begin
         if (clr_valid)
            line_valid <= 1'b0;
         else if (set_valid)
            line_valid <= 1'b1;
         if (tag_load)
            tag_r <= tag_in;
      end
   end

   // Data storage needs no reset: it is only visible once line_valid is set.
   always_ff @(posedge clk) begin
      if (we)
         line_mem[wr_idx] <= wr_data;
   end

   assign hit     = line_valid && (lookup_tag == tag_r);
   assign rd_data = line_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/rom_fetch_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rom_fetch_master : instruction fetch to AXI INCR line-burst read master
// rev 1.0
// ---------------------------------------------------------------------------
module rom_fetch_master
   import rom_fetch_master_pkg::*;
#(
   parameter logic [AXI_ID_BITS-1:0]  ARID_VAL  = '0,
   parameter logic [AXI_LEN_BITS-1:0] BURST_LEN = AXI_LEN_BITS'(DEFAULT_BURST_LEN)
) (
   input  logic                 clk,
   input  logic                 rst,
   AXI_master_intf.master       master,
   input  logic                 core_req,
   input  logic [31:0]          core_addr,
   input  logic                 core_flush,
   output logic [31:0]          core_rdata,
   output logic                 core_stall,
   output logic                 core_err
);

   localparam int BEATS_P = int'(BURST_LEN) + 1;
   localparam int IDX_W   = $clog2(BEATS_P);
   localparam int OFF_W   = IDX_W + 2;
   localparam int TAG_W   = 32 - OFF_W;

   rom_fetch_state_t state;
   logic [IDX_W-1:0] beat_cnt;
   logic             err_r;
   logic             flush_pend;

   logic [TAG_W-1:0] tag;
   logic [TAG_W-1:0] tag_r;
   logic [IDX_W-1:0] idx;
   logic             hit;
   logic [31:0]      line_word;
   logic             in_idle, in_ar, in_r, in_resp;
   logic             miss_start, keep_line;
   logic             unused_inputs;

   assign tag     = core_addr[31:OFF_W];
   assign idx     = core_addr[OFF_W-1:2];
   assign in_idle = state[IDLE_BIT];
   assign in_ar   = state[AR_BIT];
   assign in_r    = state[R_BIT];
   assign in_resp = state[RESP_BIT];

   assign miss_start = in_idle & core_req & ~hit;
   // A flush seen at any point of the fill keeps the returned line out of the buffer.
   assign keep_line  = ~err_r & ~flush_pend & ~core_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         beat_cnt   <= '0;
         err_r      <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (miss_start) begin
                  state      <= S_AR;
                  beat_cnt   <= '0;
                  err_r      <= 1'b0;
                  flush_pend <= 1'b0;
               end
            end
            S_AR: begin
               if (core_flush)
                  flush_pend <= 1'b1;
               if (master.arready)
                  state <= S_R;
            end
            S_R: begin
               if (core_flush)
                  flush_pend <= 1'b1;
               if (master.rvalid) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  err_r    <= err_r | (master.rresp != AXI_RESP_OKAY);
                  if (master.rlast)
                     state <= S_RESP;
               end
            end
            S_RESP: begin
               state      <= S_IDLE;
               flush_pend <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   fetch_line_buf #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_line_buf (
      .clk        (clk),
      .rst        (rst),
      .we         (in_r & master.rvalid),
      .wr_idx     (beat_cnt),
      .wr_data    (master.rdata),
      .tag_load   (miss_start),
      .tag_in     (tag),
      .set_valid  (in_resp & keep_line),
      .clr_valid  ((in_idle & core_flush) | miss_start | (in_resp & ~keep_line)),
      .lookup_tag (tag),
      .rd_idx     (idx),
      .hit        (hit),
      .rd_data    (line_word),
      .tag_r      (tag_r)
   );

   assign core_stall = miss_start | in_ar | in_r;
   assign core_err   = in_resp & err_r;
   assign core_rdata = ((in_idle & core_req & hit) | (in_resp & ~err_r)) ? line_word : 32'd0;

   assign master.arid    = ARID_VAL;
   assign master.araddr  = {tag_r, {OFF_W{1'b0}}};
   assign master.arlen   = BURST_LEN;
   assign master.arsize  = AXI_SIZE_WORD;
   assign master.arburst = AXI_BURST_INCR;
   assign master.arvalid = in_ar;
   assign master.rready  = in_r;

   assign master.awid    = '0;
   assign master.awaddr  = '0;
   assign master.awlen   = '0;
   assign master.awsize  = '0;
   assign master.awburst = '0;
   assign master.awvalid = 1'b0;
   assign master.wdata   = '0;
   assign master.wstrb   = '0;
   assign master.wlast   = 1'b0;
   assign master.wvalid  = 1'b0;
   assign master.bready  = 1'b0;

   assign unused_inputs = &{1'b0, master.rid, master.awready, master.wready,
                            master.bid, master.bresp, master.bvalid, core_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rom_fetch_master : directed + randomized fetches against a line-level model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_rom_fetch_master;
   import rom_fetch_master_pkg::*;

   localparam logic [AXI_ID_BITS-1:0] TB_ARID = 4'h5;
   localparam int NB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_req = 1'b0;
   logic [31:0] core_addr = 32'd0;
   logic        core_flush = 1'b0;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        core_err;

   always #5 clk = ~clk;

   AXI_master_intf axi ();

   rom_fetch_master #(
      .ARID_VAL  (TB_ARID),
      .BURST_LEN (8'd3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .master     (axi),
      .core_req   (core_req),
      .core_addr  (core_addr),
      .core_flush (core_flush),
      .core_rdata (core_rdata),
      .core_stall (core_stall),
      .core_err   (core_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // slave configuration (written by main) and slave observations (written by slave)
   int          cfg_ar_delay  = 0;
   int          cfg_rmode     = 0;
   logic [31:0] cfg_err_above = 32'h27C;

   int          ar_count = 0;
   int          ar_unstable = 0;
   int          wr_activity = 0;
   logic [31:0] last_araddr = '0;
   logic [7:0]  last_arlen = '0;
   logic [2:0]  last_arsize = '0;
   logic [1:0]  last_arburst = '0;
   logic [3:0]  last_arid = '0;

   bit          burst_act = 0;
   logic [31:0] burst_addr = '0;
   int          burst_len = 0;
   int          beat = 0;
   int          ar_wait = 0;
   bit          ar_hold = 0;
   logic [31:0] ar_hold_addr = '0;
   bit          toggle = 0;
   bit          r_go = 0;

   // reference line model
   bit          m_valid = 0;
   logic [31:0] m_base = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a >> 2) + 32'h9C;
   endfunction

   function automatic bit beat_err(input logic [31:0] a);
      return a > cfg_err_above;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   initial begin : slave
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
      axi.rlast = 1'b0; axi.rid = '0; axi.awready = 1'b0; axi.wready = 1'b0;
      axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;
      forever begin
         @(negedge clk);
         if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0 || axi.bready !== 1'b0)
            wr_activity++;
         if (rst) begin
            burst_act = 0; ar_wait = 0; ar_hold = 0;
            axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
         end else begin
            if (burst_act) begin
               case (cfg_rmode)
                  0:       r_go = 1;
                  1:       r_go = toggle;
                  default: r_go = bit'($urandom_range(0, 1));
               endcase
               toggle = !toggle;
               if (r_go) begin
                  axi.rvalid = 1'b1;
                  axi.rdata  = mem_word(burst_addr + 32'(4 * beat));
                  axi.rresp  = beat_err(burst_addr + 32'(4 * beat)) ? 2'b10 : 2'b00;
                  axi.rlast  = (beat == burst_len);
                  axi.rid    = last_arid;
                  if (axi.rready === 1'b1) begin
                     if (beat == burst_len) burst_act = 0;
                     beat++;
                  end
               end else begin
                  axi.rvalid = 1'b0;
                  axi.rlast  = 1'b0;
               end
            end else begin
               axi.rvalid = 1'b0;
               axi.rlast  = 1'b0;
            end

            axi.arready = (axi.arvalid === 1'b1) && !burst_act && (ar_wait >= cfg_ar_delay);
            if (axi.arvalid === 1'b1) begin
               if (ar_hold && axi.araddr !== ar_hold_addr) ar_unstable++;
               if (!ar_hold) begin ar_hold = 1; ar_hold_addr = axi.araddr; end
               if (axi.arready) begin
                  ar_count++;
                  last_araddr = axi.araddr; last_arlen = axi.arlen; last_arsize = axi.arsize;
                  last_arburst = axi.arburst; last_arid = axi.arid;
                  burst_act = 1; burst_addr = axi.araddr; burst_len = int'(axi.arlen);
                  beat = 0; ar_wait = 0; ar_hold = 0;
               end else begin
                  ar_wait++;
               end
            end
         end
      end
   end

   // One fetch: model predicts hit/miss, data, error and AR attributes.
   task automatic do_fetch(input logic [31:0] a, input bit exact, input int extra, input string tag);
      logic [31:0] base;
      bit          exp_hit;
      bit          exp_err;
      logic [31:0] exp_data;
      int          stalls;
      int          ar0;
      base    = {a[31:4], 4'h0};
      exp_hit = m_valid && (base == m_base);
      exp_err = 0;
      if (!exp_hit)
         for (int i = 0; i < NB; i++)
            if (beat_err(base + 32'(4 * i))) exp_err = 1;
      exp_data = exp_err ? 32'd0 : mem_word({a[31:2], 2'b00});
      stalls = 0;
      ar0    = ar_count;
      @(negedge clk);
      core_req = 1'b1; core_addr = a;
      #1;
      while (core_stall === 1'b1 && stalls < 400) begin
         @(negedge clk); #1;
         stalls++;
      end
      chk({tag, "_bounded"}, 32'(stalls < 400), 32'd1);
      chk({tag, "_rdata"}, core_rdata, exp_data);
      chk({tag, "_err"}, 32'(core_err), 32'(exp_err));
      if (exp_hit) begin
         chk({tag, "_hit_stall"}, stalls, 0);
         chk({tag, "_hit_no_ar"}, ar_count - ar0, 0);
      end else begin
         if (exact) chk({tag, "_miss_stall"}, stalls, 2 + NB + extra);
         else       chk({tag, "_miss_stall_min"}, 32'(stalls >= 2 + NB + extra), 32'd1);
         chk({tag, "_ar_once"}, ar_count - ar0, 1);
         chk({tag, "_araddr"}, last_araddr, base);
         chk({tag, "_arattr"}, {last_arid, last_arburst, last_arsize, last_arlen},
             {TB_ARID, 2'b01, 3'b010, 8'd3});
         m_valid = !exp_err;
         m_base  = base;
      end
      @(negedge clk);
      core_req = 1'b0;
      #1;
      chk({tag, "_err_pulse_end"}, 32'(core_err), 32'd0);
      chk({tag, "_idle_stall"}, 32'(core_stall), 32'd0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_arvalid"}, 32'(axi.arvalid), 32'd0);
      chk({tag, "_rready"}, 32'(axi.rready), 32'd0);
      chk({tag, "_stall"}, 32'(core_stall), 32'd0);
      chk({tag, "_err"}, 32'(core_err), 32'd0);
      chk({tag, "_rdata"}, core_rdata, 32'd0);
   endtask

   initial begin : main
      int n;
      int sel;
      int dly;
      logic [31:0] a;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk_quiet("reset");
      @(negedge clk);
      rst = 1'b0;

      // cold miss, then sequential hits, then next line
      do_fetch(32'h10, 1, 0, "cold");
      chk("cold_first_word", mem_word(32'h10), 32'hA0);
      do_fetch(32'h14, 1, 0, "hit14");
      do_fetch(32'h18, 1, 0, "hit18");
      do_fetch(32'h1C, 1, 0, "hit1c");
      do_fetch(32'h13, 1, 0, "hit13");
      do_fetch(32'h20, 1, 0, "next_line");

      // slow slave: AR stalled 5 cycles, R toggling
      cfg_ar_delay = 5; cfg_rmode = 1;
      do_fetch(32'h40, 0, 5, "slow");
      chk("slow_ar_stable", ar_unstable, 0);
      do_fetch(32'h44, 1, 0, "slow_hit44");
      do_fetch(32'h48, 1, 0, "slow_hit48");
      do_fetch(32'h4C, 1, 0, "slow_hit4c");
      cfg_ar_delay = 0; cfg_rmode = 0;

      // beat 2 of line 0x70 returns SLVERR
      cfg_err_above = 32'h74;
      do_fetch(32'h70, 1, 0, "slverr");
      do_fetch(32'h70, 1, 0, "slverr_again");
      cfg_err_above = 32'h27C;
      do_fetch(32'h284, 1, 0, "slverr_hi");

      // flush in IDLE alongside a hit
      do_fetch(32'h10, 1, 0, "refill10");
      @(negedge clk);
      core_req = 1'b1; core_addr = 32'h14; core_flush = 1'b1;
      #1;
      chk("flush_idle_stall", 32'(core_stall), 32'd0);
      chk("flush_idle_rdata", core_rdata, mem_word(32'h14));
      @(negedge clk);
      core_req = 1'b0; core_flush = 1'b0;
      m_valid = 0;
      do_fetch(32'h14, 1, 0, "after_flush_idle");

      // flush during the R phase: data delivered, line not retained
      @(negedge clk);
      core_req = 1'b1; core_addr = 32'h30;
      n = 0;
      #1;
      while (axi.rready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      chk("flush_r_reached", 32'(n < 100), 32'd1);
      core_flush = 1'b1;
      @(negedge clk);
      core_flush = 1'b0;
      n = 0;
      #1;
      while (core_stall === 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      chk("flush_r_rdata", core_rdata, mem_word(32'h30));
      chk("flush_r_err", 32'(core_err), 32'd0);
      @(negedge clk);
      core_req = 1'b0;
      m_valid = 0;
      do_fetch(32'h34, 1, 0, "after_flush_r");

      // reset in the middle of a burst
      @(negedge clk);
      core_req = 1'b1; core_addr = 32'h50;
      n = 0;
      #1;
      while (axi.rready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      chk("rst_r_reached", 32'(n < 100), 32'd1);
      @(negedge clk);
      core_req = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk_quiet("midrst");
      @(negedge clk);
      rst = 1'b0;
      m_valid = 0;
      do_fetch(32'h34, 1, 0, "after_rst");

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 8)       a = 32'(sel) << 4;
         else if (sel == 8) a = 32'h270;
         else               a = 32'h280;
         a = a | 32'($urandom_range(0, 15));
         dly = int'($urandom_range(0, 3));
         cfg_ar_delay = dly;
         cfg_rmode    = int'($urandom_range(0, 2));
         do_fetch(a, cfg_rmode == 0, dly, $sformatf("rnd%0d", it));
      end

      chk("ar_stable_all", ar_unstable, 0);
      chk("write_channels_idle", wr_activity, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
